dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_responder_if.sv | 35 +++
 rtl/dmem_byte_array.sv | 28 ++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane geometry for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_BAD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_W    = 32;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = WORD_W / LANE_W;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the memory stage and the responder.
// DMEM_SIGNED_LOAD_EN adds the req_signed_i request field.
interface dmem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
`ifdef DMEM_SIGNED_LOAD_EN
  logic              req_signed_i;
`endif
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
`ifdef DMEM_SIGNED_LOAD_EN
    output req_signed_i,
`endif
    output req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
`ifdef DMEM_SIGNED_LOAD_EN
    input  req_signed_i,
`endif
    input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_byte_array.sv
// Byte-lane storage: one array per lane, shared word index, per-lane write enable, registered read.
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int ELEM_W = 8
) (
  input  logic                        clk,
  input  logic [IDX_W-1:0]            idx,
  input  logic [NUM_LANES-1:0]        lane_we,
  input  logic [NUM_LANES*ELEM_W-1:0] wdata,
  output logic [NUM_LANES*ELEM_W-1:0] rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [ELEM_W-1:0] mem [2**IDX_W];
    logic [ELEM_W-1:0] rd_q;

    // read-during-write returns the old byte; the responder never needs the new one
    always_ff @(posedge clk) begin
      if (lane_we[l]) mem[idx] <= wdata[l*ELEM_W +: ELEM_W];
      rd_q <= mem[idx];
    end

    assign rdata[l*ELEM_W +: ELEM_W] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts a load/store, waits LATENCY cycles, then answers with a one-cycle pulse.
// Optional: DMEM_SIGNED_LOAD_EN enables sign-extended byte/half loads via req_signed_i.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ELEM_W  = 8,
  parameter int DEPTH_W = 10,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  dmem_responder_if.slave bus
);

  localparam int OFF_W = $clog2(NUM_LANES);
  localparam int IDX_W = DEPTH_W - OFF_W;

  state_e               state, state_n;
  logic [3:0]           wait_cnt, wait_cnt_n;
  logic                 accept, exec, fault;

  logic                 we_p0;
  size_e                size_p0;
  logic [ADDR_W-1:0]    addr_p0;
  logic [DATA_W-1:0]    wdata_p0;
  logic                 sgn_p0;

  logic [DATA_W-1:0]    rdata_p1;
  logic                 err_p1;

  logic [IDX_W-1:0]     idx;
  logic [NUM_LANES-1:0] lane_we;
  logic [DATA_W-1:0]    rdata_raw;

  function automatic logic access_fault(size_e sz, logic [ADDR_W-1:0] a);
    logic f;
    f = (a >> DEPTH_W) != '0;
    case (sz)
      SZ_H:    f = f | a[0];
      SZ_W:    f = f | (a[OFF_W-1:0] != '0);
      SZ_BAD:  f = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_mask(size_e sz, logic [OFF_W-1:0] off);
    logic [NUM_LANES-1:0] m;
    case (sz)
      SZ_B:    m = NUM_LANES'(1) << off;
      SZ_H:    m = NUM_LANES'(3) << off;
      default: m = '1;
    endcase
    return m;
  endfunction

  // Replicate narrow store data across every lane so the lane mask alone picks the bytes.
  function automatic logic [DATA_W-1:0] steer_wdata(logic [DATA_W-1:0] wd, size_e sz);
    logic [DATA_W-1:0] s;
    case (sz)
      SZ_B:    s = {NUM_LANES{wd[ELEM_W-1:0]}};
      SZ_H:    s = {(NUM_LANES/2){wd[2*ELEM_W-1:0]}};
      default: s = wd;
    endcase
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(logic [DATA_W-1:0] raw, size_e sz,
                                                 logic [OFF_W-1:0] off, logic sgn);
    logic        [DATA_W-1:0]   sh;
    logic signed [ELEM_W-1:0]   b_s;
    logic signed [2*ELEM_W-1:0] h_s;
    logic signed [DATA_W-1:0]   ext;
    sh  = raw >> (ELEM_W * off);
    b_s = sh[ELEM_W-1:0];
    h_s = sh[2*ELEM_W-1:0];
    case (sz)
      SZ_B:    if (sgn) ext = DATA_W'(b_s); else ext = DATA_W'(sh[ELEM_W-1:0]);
      SZ_H:    if (sgn) ext = DATA_W'(h_s); else ext = DATA_W'(sh[2*ELEM_W-1:0]);
      default: ext = sh;
    endcase
    return ext;
  endfunction

  assign bus.req_ready_o = (state != WAIT);
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign exec            = (state == WAIT) && (wait_cnt == 4'd0);
  assign fault           = access_fault(size_p0, addr_p0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      IDLE: if (accept) begin
        state_n    = WAIT;
        wait_cnt_n = 4'(LATENCY - 1);
      end
      WAIT: if (wait_cnt == 4'd0) state_n = RESP;
            else                  wait_cnt_n = wait_cnt - 4'd1;
      RESP: if (accept) begin
        state_n    = WAIT;
        wait_cnt_n = 4'(LATENCY - 1);
      end else begin
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // p0: request captured at accept, held through WAIT
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we_i;
      size_p0  <= size_e'(bus.req_size_i);
      addr_p0  <= bus.req_addr_i;
      wdata_p0 <= bus.req_wdata_i;
`ifdef DMEM_SIGNED_LOAD_EN
      sgn_p0   <= bus.req_signed_i;
`else
      sgn_p0   <= 1'b0;
`endif
    end
  end

  // The array is read every cycle, using the incoming address on the accept edge so
  // read data is already stable by the execute edge even when LATENCY is 1.
  assign idx     = accept ? bus.req_addr_i[DEPTH_W-1:OFF_W] : addr_p0[DEPTH_W-1:OFF_W];
  assign lane_we = (exec && we_p0 && !fault && !reset) ?
                   lane_mask(size_p0, addr_p0[OFF_W-1:0]) : '0;

  dmem_byte_array #(
    .IDX_W  (IDX_W),
    .ELEM_W (ELEM_W)
  ) u_array (
    .clk     (clk),
    .idx     (idx),
    .lane_we (lane_we),
    .wdata   (steer_wdata(wdata_p0, size_p0)),
    .rdata   (rdata_raw)
  );

  // p1: response registers, updated on the execute edge and held until the next one
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (exec) begin
      err_p1   <= fault;
      rdata_p1 <= (fault || we_p0) ? '0 :
                  load_ext(rdata_raw, size_p0, addr_p0[OFF_W-1:0], sgn_p0);
    end
  end

  assign bus.rsp_valid_o = (state == RESP);
  assign bus.rsp_rdata_o = rdata_p1;
  assign bus.rsp_err_o   = err_p1;

endmodule
